// File: rtl/gpio_pkg.sv
// Shared constants and helpers for the GPIO event conditioner.
package gpio_pkg;

    localparam int unsigned MODE_W = 2;

    typedef logic [MODE_W-1:0] edge_mode_t;

    localparam edge_mode_t EDGE_OFF  = 2'b00;
    localparam edge_mode_t EDGE_RISE = 2'b01;
    localparam edge_mode_t EDGE_FALL = 2'b10;
    localparam edge_mode_t EDGE_BOTH = 2'b11;

    // True when an accepted transition to new_level is a qualifying edge for mode.
    function automatic logic edge_allowed(input edge_mode_t mode, input logic new_level);
        if (new_level) begin
            return (mode == EDGE_RISE) || (mode == EDGE_BOTH);
        end
        return (mode == EDGE_FALL) || (mode == EDGE_BOTH);
    endfunction

endpackage

// File: rtl/gpio_event_unit_if.sv
// Control/status bundle between the pin conditioner and its host.
interface gpio_event_unit_if #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DEBOUNCE_W = 8
);
    logic                    ena;
    logic [NUM_CH-1:0]       gpio_in;
    logic [2*NUM_CH-1:0]     edge_mode;
    logic [DEBOUNCE_W-1:0]   debounce_limit;
    logic [NUM_CH-1:0]       event_clr;
    logic [NUM_CH-1:0]       gpio_level;
    logic [NUM_CH-1:0]       gpio_event;
    logic [NUM_CH-1:0]       event_pending;
    logic                    irq;

    modport master (
        output ena, gpio_in, edge_mode, debounce_limit, event_clr,
        input  gpio_level, gpio_event, event_pending, irq
    );

    modport slave (
        input  ena, gpio_in, edge_mode, debounce_limit, event_clr,
        output gpio_level, gpio_event, event_pending, irq
    );
endinterface

// File: rtl/gpio_channel.sv
// One GPIO channel: synchroniser, debounce counter, level, edge event and pending flag.
module gpio_channel
    import gpio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  pin,
    input  edge_mode_t            mode,
    input  logic [DEBOUNCE_W-1:0] limit,
    input  logic                  clr,
    output logic                  level,
    output logic                  evt,
    output logic                  pending
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   deb_in_q;
    logic [DEBOUNCE_W-1:0]  cnt_q;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Synchroniser chain plus the registered sample the debouncer compares against.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            deb_in_q <= 1'b0;
        end else if (ena) begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pin};
            deb_in_q <= sync_out;
        end
    end

    // Debounce: accept a new level once it has differed for limit+1 enabled cycles.
    // The >= compare lets a lowered limit take effect on a count already past it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            level <= 1'b0;
            evt   <= 1'b0;
        end else begin
            evt <= 1'b0;
            if (ena) begin
                if (deb_in_q == level) begin
                    cnt_q <= '0;
                end else if (cnt_q >= limit) begin
                    level <= deb_in_q;
                    cnt_q <= '0;
                    evt   <= edge_allowed(mode, deb_in_q);
                end else begin
                    cnt_q <= cnt_q + DEBOUNCE_W'(1);
                end
            end
        end
    end

    // Sticky pending flag; a new event beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (evt) begin
            pending <= 1'b1;
        end else if (clr) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/gpio_event_unit.sv
// Multi-channel GPIO input conditioner with per-channel edge events and a shared irq.
module gpio_event_unit
    import gpio_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    gpio_event_unit_if.slave   bus
);

    logic [NUM_CH-1:0] level;
    logic [NUM_CH-1:0] evt;
    logic [NUM_CH-1:0] pend;
    logic              irq_q;

    // One conditioner per pin, each with its own mode slice and clear bit.
    for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
        gpio_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_W  (DEBOUNCE_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .ena     (bus.ena),
            .pin     (bus.gpio_in[i]),
            .mode    (bus.edge_mode[MODE_W*i +: MODE_W]),
            .limit   (bus.debounce_limit),
            .clr     (bus.event_clr[i]),
            .level   (level[i]),
            .evt     (evt[i]),
            .pending (pend[i])
        );
    end

    // Interrupt is the registered OR of all pending flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |pend;
        end
    end

    assign bus.gpio_level    = level;
    assign bus.gpio_event    = evt;
    assign bus.event_pending = pend;
    assign bus.irq           = irq_q;

endmodule

// File: tb/tb_gpio_event_unit.sv
// Directed + randomized bench for gpio_event_unit against a delay-line/streak reference model.
module tb_gpio_event_unit;

    localparam int unsigned NUM_CH      = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned DEBOUNCE_W  = 8;
    localparam int unsigned MODE_BITS   = 2 * NUM_CH;
    // Pin value seen by the debounce rule lags the pin by this many enabled edges.
    localparam int unsigned PIPE        = SYNC_STAGES + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gpio_event_unit_if #(.NUM_CH(NUM_CH), .DEBOUNCE_W(DEBOUNCE_W)) bus ();

    gpio_event_unit #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE_W  (DEBOUNCE_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit                m_hist [NUM_CH][$];
    int                m_run  [NUM_CH];
    logic [NUM_CH-1:0] m_level, m_evt, m_pend;
    logic              m_irq;
    int                ev_cnt [NUM_CH];

    task automatic model_reset();
        for (int ch = 0; ch < int'(NUM_CH); ch++) begin
            m_hist[ch].delete();
            repeat (PIPE) m_hist[ch].push_back(1'b0);
            m_run[ch] = 0;
        end
        m_level = '0;
        m_evt   = '0;
        m_pend  = '0;
        m_irq   = 1'b0;
    endtask

    // One clock edge: level flips after limit+1 consecutive differing delayed samples.
    task automatic model_edge();
        logic [NUM_CH-1:0] nevt;
        logic [NUM_CH-1:0] npend;
        logic [1:0]        md;
        bit                seen;
        nevt  = '0;
        npend = (m_pend & ~bus.event_clr) | m_evt;
        m_irq = |m_pend;
        if (bus.ena) begin
            for (int ch = 0; ch < int'(NUM_CH); ch++) begin
                seen = m_hist[ch].pop_front();
                m_hist[ch].push_back(bus.gpio_in[ch]);
                md = bus.edge_mode[2*ch +: 2];
                if (seen == m_level[ch]) begin
                    m_run[ch] = 0;
                end else if (m_run[ch] >= int'(bus.debounce_limit)) begin
                    m_level[ch] = seen;
                    m_run[ch]   = 0;
                    case (md)
                        2'b01:   nevt[ch] = seen;
                        2'b10:   nevt[ch] = !seen;
                        2'b11:   nevt[ch] = 1'b1;
                        default: nevt[ch] = 1'b0;
                    endcase
                end else begin
                    m_run[ch] = m_run[ch] + 1;
                end
            end
        end
        m_evt  = nevt;
        m_pend = npend;
    endtask

    task automatic chk_vec(input string tag, input logic [NUM_CH-1:0] obs, input logic [NUM_CH-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk_vec("gpio_level", bus.gpio_level, m_level);
        chk_vec("gpio_event", bus.gpio_event, m_evt);
        chk_vec("event_pending", bus.event_pending, m_pend);
        chk_vec("irq", NUM_CH'(bus.irq), NUM_CH'(m_irq));
    endtask

    // Inputs are changed only at the falling edge; outputs are checked there too.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
        for (int ch = 0; ch < int'(NUM_CH); ch++)
            if (bus.gpio_event[ch]) ev_cnt[ch]++;
    endtask

    task automatic clear_counts();
        for (int ch = 0; ch < int'(NUM_CH); ch++) ev_cnt[ch] = 0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise_at;
        bit glitch_rose;

        rst                = 1'b1;
        bus.ena            = 1'b1;
        bus.gpio_in        = '0;
        bus.edge_mode      = '0;
        bus.debounce_limit = DEBOUNCE_W'(3);
        bus.event_clr      = '0;
        model_reset();
        clear_counts();
        @(negedge clk);
        check_all();
        chk_vec("reset_level", bus.gpio_level, '0);
        rst = 1'b0;

        // Rise on ch0 with limit 3: level changes six edges after first sample.
        bus.edge_mode  = MODE_BITS'(8'b00_00_00_01);
        bus.gpio_in[0] = 1'b1;
        rise_at = -1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (rise_at < 0 && bus.gpio_level[0]) rise_at = i;
        end
        chk_int("t1_latency", rise_at, 6);
        chk_int("t1_events", ev_cnt[0], 1);

        // ch1 both-edges: 3-cycle glitch rejected, 4-cycle pulse accepted twice.
        clear_counts();
        bus.edge_mode  = MODE_BITS'(8'b00_00_11_01);
        bus.gpio_in[1] = 1'b1;
        glitch_rose = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.gpio_level[1]) glitch_rose = 1'b1;
        end
        bus.gpio_in[1] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.gpio_level[1]) glitch_rose = 1'b1;
        end
        chk_int("t2_glitch_level", int'(glitch_rose), 0);
        chk_int("t2_glitch_events", ev_cnt[1], 0);
        bus.gpio_in[1] = 1'b1;
        steps(4);
        bus.gpio_in[1] = 1'b0;
        steps(16);
        chk_int("t2_pulse_events", ev_cnt[1], 2);

        // ch2 fall-only: level follows both edges, only the fall pulses.
        clear_counts();
        bus.edge_mode  = MODE_BITS'(8'b00_10_11_01);
        bus.gpio_in[2] = 1'b1;
        steps(20);
        chk_int("t3_level_high", int'(bus.gpio_level[2]), 1);
        chk_int("t3_no_rise_event", ev_cnt[2], 0);
        bus.gpio_in[2] = 1'b0;
        steps(20);
        chk_int("t3_level_low", int'(bus.gpio_level[2]), 0);
        chk_int("t3_fall_events", ev_cnt[2], 1);

        // ch0: clear coinciding with a new event leaves pending set.
        bus.gpio_in[0] = 1'b0;
        steps(20);
        bus.event_clr[0] = 1'b1;
        step();
        bus.event_clr[0] = 1'b0;
        steps(2);
        chk_int("t4_cleared", int'(bus.event_pending[0]), 0);
        bus.gpio_in[0] = 1'b1;
        for (int i = 0; i < 30 && !bus.gpio_event[0]; i++) step();
        chk_int("t4_event_seen", int'(bus.gpio_event[0]), 1);
        bus.event_clr[0] = 1'b1;
        step();
        bus.event_clr[0] = 1'b0;
        chk_int("t4_set_wins", int'(bus.event_pending[0]), 1);
        steps(3);
        bus.event_clr = '1;
        step();
        bus.event_clr = '0;
        chk_int("t4_lone_clr", int'(bus.event_pending[0]), 0);
        step();
        chk_int("t4_irq_low", int'(bus.irq), 0);

        // ch3: ten disabled cycles mid-debounce stretch latency by exactly ten.
        bus.edge_mode  = MODE_BITS'(8'b11_10_11_01);
        bus.gpio_in[3] = 1'b1;
        rise_at = -1;
        for (int i = 0; i < 40; i++) begin
            bus.ena = !(i >= 4 && i < 14);
            step();
            if (rise_at < 0 && bus.gpio_level[3]) rise_at = i;
        end
        bus.ena = 1'b1;
        chk_int("t5_latency", rise_at, 16);

        // Randomized traffic: pins, enables, clears, modes and limits.
        for (int i = 0; i < 400; i++) begin
            for (int ch = 0; ch < int'(NUM_CH); ch++)
                if ($urandom_range(0, 5) == 0) bus.gpio_in[ch] = ~bus.gpio_in[ch];
            bus.ena       = ($urandom_range(0, 7) != 0);
            bus.event_clr = NUM_CH'($urandom) & NUM_CH'($urandom) & NUM_CH'($urandom);
            if ($urandom_range(0, 15) == 0) bus.edge_mode = MODE_BITS'($urandom);
            if ($urandom_range(0, 20) == 0) bus.debounce_limit = DEBOUNCE_W'($urandom_range(0, 4));
            step();
        end

        // Async reset mid-count: outputs drop at once, full latency after release.
        bus.ena            = 1'b1;
        bus.event_clr      = '0;
        bus.gpio_in        = '0;
        bus.debounce_limit = DEBOUNCE_W'(3);
        bus.edge_mode      = MODE_BITS'(8'b00_00_00_01);
        steps(30);
        bus.gpio_in[0] = 1'b1;
        bus.gpio_in[1] = 1'b1;
        steps(20);
        bus.gpio_in[1] = 1'b0;
        steps(5);
        #2 rst = 1'b1;
        #1;
        chk_vec("t6_rst_level", bus.gpio_level, '0);
        chk_vec("t6_rst_event", bus.gpio_event, '0);
        chk_vec("t6_rst_pending", bus.event_pending, '0);
        chk_int("t6_rst_irq", int'(bus.irq), 0);
        model_reset();
        clear_counts();
        @(negedge clk);
        rst = 1'b0;
        rise_at = -1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (rise_at < 0 && bus.gpio_level[0]) rise_at = i;
        end
        chk_int("t6_latency", rise_at, 6);
        chk_int("t6_events", ev_cnt[0], 1);
        chk_int("t6_irq", int'(bus.irq), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
